// File: rtl/dm_cache_pkg.sv
// Shared definitions for the parameterised direct-mapped cache.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WT_WRITE,
    EVICT,
    REFILL,
    RESP
  } state_e;

  // Write policy selector values for WRITE_BACK.
  localparam int WT_NOALLOC = 0;
  localparam int WB_ALLOC   = 1;

  // Statistics counters stick at this value.
  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_SAT) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/valid/dirty/data storage: one read/write port, combinational read, synchronous write.
module dm_cache_array #(
  parameter int unsigned TAG_W       = 26,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned OFF_W       = 2,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] idx,
  input  logic [OFF_W-1:0]       woff,
  input  logic                   data_we,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   meta_we,
  input  logic [TAG_W-1:0]       tag_in,
  input  logic                   valid_in,
  input  logic                   dirty_in,
  output logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS = 1 << OFF_W;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES*WORDS];
  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;

  // Per-line status bit update.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (meta_we) begin
      valid_d[idx] = valid_in;
      dirty_d[idx] = dirty_in;
    end
  end

  // Status bits are the only reset storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (meta_we) tag_mem[idx] <= tag_in;
    if (data_we) data_mem[{idx, woff}] <= wdata;
  end

  assign rd_tag   = tag_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_data  = data_mem[{idx, woff}];

endmodule

// File: rtl/dm_cache_param.sv
// Direct-mapped cache with selectable write-through or write-back policy and
// a single-word lower-memory handshake.
module dm_cache_param
  import dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INDEX_WIDTH    = 6,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int          WRITE_BACK     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  u_req,
  input  logic                  u_we,
  input  logic [ADDR_WIDTH-1:0] u_addr,
  input  logic [DATA_WIDTH-1:0] u_wdata,
  output logic                  u_ready,
  output logic                  u_valid,
  output logic [DATA_WIDTH-1:0] u_rdata,
  output logic                  l_req,
  output logic                  l_we,
  output logic [ADDR_WIDTH-1:0] l_addr,
  output logic [DATA_WIDTH-1:0] l_wdata,
  input  logic [DATA_WIDTH-1:0] l_rdata,
  input  logic                  l_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_W  = ADDR_WIDTH - INDEX_WIDTH - OFF_W - BYTE_W;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [OFF_W-1:0]        beat_q, beat_d;
  logic                    l_req_q, l_req_d;
  logic                    l_we_q, l_we_d;
  logic [ADDR_WIDTH-1:0]   l_addr_q, l_addr_d;
  logic [DATA_WIDTH-1:0]   l_wdata_q, l_wdata_d;
  logic                    u_valid_q, u_valid_d;
  logic [DATA_WIDTH-1:0]   u_rdata_q, u_rdata_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]        tag_f;
  logic [INDEX_WIDTH-1:0]  idx_f;
  logic [OFF_W-1:0]        off_f;
  logic                    hit;

  logic [OFF_W-1:0]        arr_woff;
  logic                    arr_data_we;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic                    arr_meta_we;
  logic                    arr_dirty_in;
  logic [TAG_W-1:0]        arr_rd_tag;
  logic                    arr_rd_valid;
  logic                    arr_rd_dirty;
  logic [DATA_WIDTH-1:0]   arr_rd_data;

  // Byte-lane address bits are don't-care for a word-wide cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q;

  assign tag_f = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign idx_f = addr_q[BYTE_W+OFF_W +: INDEX_WIDTH];
  assign off_f = addr_q[BYTE_W +: OFF_W];
  assign hit   = arr_rd_valid && (arr_rd_tag == tag_f);

  // Line bursts walk the words with the beat counter; otherwise the requested word.
  assign arr_woff = (state_q == EVICT || state_q == REFILL) ? beat_q : off_f;

  function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [TAG_W-1:0]       t,
                                                    input logic [INDEX_WIDTH-1:0] i,
                                                    input logic [OFF_W-1:0]       o);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1 -: TAG_W]        = t;
    a[BYTE_W+OFF_W +: INDEX_WIDTH]  = i;
    a[BYTE_W +: OFF_W]              = o;
    return a;
  endfunction

  dm_cache_array #(
    .TAG_W       (TAG_W),
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFF_W       (OFF_W),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx_f),
    .woff     (arr_woff),
    .data_we  (arr_data_we),
    .wdata    (arr_wdata),
    .meta_we  (arr_meta_we),
    .tag_in   (tag_f),
    .valid_in (1'b1),
    .dirty_in (arr_dirty_in),
    .rd_tag   (arr_rd_tag),
    .rd_valid (arr_rd_valid),
    .rd_dirty (arr_rd_dirty),
    .rd_data  (arr_rd_data)
  );

  // Next-state, lower-handshake and array-write control.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    beat_d       = beat_q;
    l_req_d      = l_req_q;
    l_we_d       = l_we_q;
    l_addr_d     = l_addr_q;
    l_wdata_d    = l_wdata_q;
    u_rdata_d    = u_rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    arr_data_we  = 1'b0;
    arr_wdata    = wdata_q;
    arr_meta_we  = 1'b0;
    arr_dirty_in = 1'b0;

    case (state_q)
      IDLE: begin
        if (u_req) begin
          addr_d  = u_addr;
          wdata_d = u_wdata;
          we_d    = u_we;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        beat_d = '0;
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          if (!we_q) begin
            u_rdata_d = arr_rd_data;
            state_d   = RESP;
          end else begin
            arr_data_we = 1'b1;
            if (WRITE_BACK == WB_ALLOC) begin
              arr_meta_we  = 1'b1;
              arr_dirty_in = 1'b1;
              state_d      = RESP;
            end else begin
              state_d = WT_WRITE;
            end
          end
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          if (we_q && WRITE_BACK == WT_NOALLOC) begin
            state_d = WT_WRITE;
          end else if (WRITE_BACK == WB_ALLOC && arr_rd_valid && arr_rd_dirty) begin
            state_d = EVICT;
          end else begin
            state_d = REFILL;
          end
        end
      end

      WT_WRITE: begin
        if (!l_req_q) begin
          l_req_d   = 1'b1;
          l_we_d    = 1'b1;
          l_addr_d  = mk_addr(tag_f, idx_f, off_f);
          l_wdata_d = wdata_q;
        end else if (l_ack) begin
          l_req_d = 1'b0;
          l_we_d  = 1'b0;
          state_d = RESP;
        end
      end

      EVICT: begin
        if (!l_req_q) begin
          l_req_d   = 1'b1;
          l_we_d    = 1'b1;
          l_addr_d  = mk_addr(arr_rd_tag, idx_f, beat_q);
          l_wdata_d = arr_rd_data;
        end else if (l_ack) begin
          l_req_d = 1'b0;
          l_we_d  = 1'b0;
          beat_d  = beat_q + 1'b1;
          if (beat_q == '1) state_d = REFILL;
        end
      end

      REFILL: begin
        if (!l_req_q) begin
          l_req_d  = 1'b1;
          l_we_d   = 1'b0;
          l_addr_d = mk_addr(tag_f, idx_f, beat_q);
        end else if (l_ack) begin
          l_req_d     = 1'b0;
          arr_data_we = 1'b1;
          // The requested word is merged/returned as its beat lands, so the
          // line is complete on the final beat and no second pass is needed.
          arr_wdata   = (we_q && beat_q == off_f) ? wdata_q : l_rdata;
          if (!we_q && beat_q == off_f) u_rdata_d = l_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) begin
            arr_meta_we  = 1'b1;
            arr_dirty_in = we_q && (WRITE_BACK == WB_ALLOC);
            state_d      = RESP;
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    u_valid_d = (state_d == RESP);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      beat_q     <= '0;
      l_req_q    <= 1'b0;
      l_we_q     <= 1'b0;
      l_addr_q   <= '0;
      l_wdata_q  <= '0;
      u_valid_q  <= 1'b0;
      u_rdata_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      beat_q     <= beat_d;
      l_req_q    <= l_req_d;
      l_we_q     <= l_we_d;
      l_addr_q   <= l_addr_d;
      l_wdata_q  <= l_wdata_d;
      u_valid_q  <= u_valid_d;
      u_rdata_q  <= u_rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign u_ready  = (state_q == IDLE);
  assign u_valid  = u_valid_q;
  assign u_rdata  = u_rdata_q;
  assign l_req    = l_req_q;
  assign l_we     = l_we_q;
  assign l_addr   = l_addr_q;
  assign l_wdata  = l_wdata_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_param.sv
// Directed bench: a write-through and a write-back instance share one lower
// memory model; sel picks which one is driven and observed.
module tb_dm_cache_param;

  logic clk, rst, sel;
  logic u_req, u_we;
  logic [31:0] u_addr, u_wdata;
  logic [31:0] l_rdata;
  logic l_ack;

  logic u_ready0, u_valid0, l_req0, l_we0, l_ack0;
  logic [31:0] u_rdata0, l_addr0, l_wdata0, hit_cnt0, miss_cnt0;
  logic u_ready1, u_valid1, l_req1, l_we1, l_ack1;
  logic [31:0] u_rdata1, l_addr1, l_wdata1, hit_cnt1, miss_cnt1;
  logic u_req0, u_req1;

  logic u_ready, u_valid, l_req, l_we;
  logic [31:0] u_rdata, l_addr, l_wdata, hit_cnt, miss_cnt;

  int errors = 0;
  int checks = 0;

  assign u_req0 = u_req & ~sel;
  assign u_req1 = u_req & sel;
  assign l_ack0 = l_ack & ~sel;
  assign l_ack1 = l_ack & sel;
  assign u_ready  = sel ? u_ready1  : u_ready0;
  assign u_valid  = sel ? u_valid1  : u_valid0;
  assign u_rdata  = sel ? u_rdata1  : u_rdata0;
  assign l_req    = sel ? l_req1    : l_req0;
  assign l_we     = sel ? l_we1     : l_we0;
  assign l_addr   = sel ? l_addr1   : l_addr0;
  assign l_wdata  = sel ? l_wdata1  : l_wdata0;
  assign hit_cnt  = sel ? hit_cnt1  : hit_cnt0;
  assign miss_cnt = sel ? miss_cnt1 : miss_cnt0;

  dm_cache_param #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_WIDTH(2),
                   .WORDS_PER_LINE(4), .WRITE_BACK(0)) dut0 (
    .clk(clk), .rst(rst), .u_req(u_req0), .u_we(u_we), .u_addr(u_addr),
    .u_wdata(u_wdata), .u_ready(u_ready0), .u_valid(u_valid0), .u_rdata(u_rdata0),
    .l_req(l_req0), .l_we(l_we0), .l_addr(l_addr0), .l_wdata(l_wdata0),
    .l_rdata(l_rdata), .l_ack(l_ack0), .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0));

  dm_cache_param #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_WIDTH(2),
                   .WORDS_PER_LINE(4), .WRITE_BACK(1)) dut1 (
    .clk(clk), .rst(rst), .u_req(u_req1), .u_we(u_we), .u_addr(u_addr),
    .u_wdata(u_wdata), .u_ready(u_ready1), .u_valid(u_valid1), .u_rdata(u_rdata1),
    .l_req(l_req1), .l_we(l_we1), .l_addr(l_addr1), .l_wdata(l_wdata1),
    .l_rdata(l_rdata), .l_ack(l_ack1), .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lower memory model: word at byte address A initialised to 0x1000_0000|A.
  logic [31:0] mem [64];
  int ack_delay = 0;
  int wait_cnt = 0;
  bit in_beat = 0;
  bit req_seen = 0;
  int stab_viol = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic cur_we;
  logic [31:0] log_addr[$], log_data[$];
  logic log_we[$];
  int log_wait[$];

  always @(negedge clk) begin
    if (rst) begin
      l_ack = 1'b0; in_beat = 0; wait_cnt = 0;
    end else if (l_ack) begin
      l_ack = 1'b0;
    end else if (l_req) begin
      req_seen = 1;
      if (!in_beat) begin
        in_beat = 1; wait_cnt = 0;
        cur_addr = l_addr; cur_wdata = l_wdata; cur_we = l_we;
      end else if (l_addr !== cur_addr || l_wdata !== cur_wdata || l_we !== cur_we) begin
        stab_viol++;
      end
      if (wait_cnt == ack_delay) begin
        l_ack = 1'b1; in_beat = 0;
        if (l_we) mem[l_addr[7:2]] = l_wdata;
        else l_rdata = mem[l_addr[7:2]];
        log_addr.push_back(l_addr); log_we.push_back(l_we);
        log_data.push_back(l_we ? l_wdata : mem[l_addr[7:2]]);
        log_wait.push_back(wait_cnt);
      end else begin
        wait_cnt++;
      end
    end else if (in_beat) begin
      stab_viol++; in_beat = 0;
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i * 4);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); log_data.delete(); log_wait.delete();
    req_seen = 0;
  endtask

  // Issues one access from a negedge and returns at the negedge where u_valid is high.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output int acc_wait);
    u_we = we; u_addr = addr; u_wdata = wd; u_req = 1'b1; acc_wait = 0;
    while (!u_ready && acc_wait < 100) begin @(negedge clk); acc_wait++; end
    @(negedge clk); u_req = 1'b0; lat = 1;
    while (!u_valid && lat < 400) begin @(negedge clk); lat++; end
    if (!u_valid) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h lat=%0d", addr, lat);
    end
    rd = u_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; u_req = 1'b0; u_we = 1'b0; u_addr = '0; u_wdata = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      checks++; if ({u_ready, u_valid, l_req, l_we} !== 4'b1000) begin errors++;
        $display("FAIL reset_ctl dut%0d got=%b exp=1000", s, {u_ready, u_valid, l_req, l_we}); end
      checks++; if ({u_rdata, l_addr, l_wdata} !== 96'h0) begin errors++;
        $display("FAIL reset_data dut%0d got=%h exp=0", s, {u_rdata, l_addr, l_wdata}); end
      checks++; if ({hit_cnt, miss_cnt} !== 64'h0) begin errors++;
        $display("FAIL reset_cnt dut%0d got=%h exp=0", s, {hit_cnt, miss_cnt}); end
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int lat, aw;
    clear_log();
    do_access(1'b0, 32'h10, '0, rd, lat, aw);
    checks++; if (rd !== 32'h1000_0010) begin errors++;
      $display("FAIL cold_rdata got=%h exp=%h", rd, 32'h1000_0010); end
    checks++; if (log_addr.size() != 4) begin errors++;
      $display("FAIL cold_beats got=%0d exp=4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++; if (log_addr[i] !== 32'h10 + 32'(4 * i) || log_we[i] !== 1'b0) begin errors++;
        $display("FAIL cold_beat%0d got=%h/%b exp=%h/0", i, log_addr[i], log_we[i], 32'h10 + 32'(4 * i)); end
    end
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++;
      $display("FAIL cold_cnt got=%0d/%0d exp=1/0", miss_cnt, hit_cnt); end
    @(negedge clk);
    checks++; if (u_valid !== 1'b0 || u_ready !== 1'b1) begin errors++;
      $display("FAIL valid_pulse got=%b%b exp=01", u_valid, u_ready); end
    clear_log();
    do_access(1'b0, 32'h14, '0, rd, lat, aw);
    checks++; if (rd !== 32'h1000_0014) begin errors++;
      $display("FAIL hit_rdata got=%h exp=%h", rd, 32'h1000_0014); end
    checks++; if (lat != 2) begin errors++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++; if (req_seen) begin errors++; $display("FAIL hit_lower got=1 exp=0"); end
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL hit_cnt got=%0d exp=1", hit_cnt); end
  endtask

  task automatic test_wt_write();
    logic [31:0] rd; int lat, aw;
    clear_log();
    do_access(1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat, aw);
    checks++; if (log_addr.size() != 1) begin errors++;
      $display("FAIL wt_hit_beats got=%0d exp=1", log_addr.size()); end
    else begin
      checks++; if (log_addr[0] !== 32'h10 || log_we[0] !== 1'b1 || log_data[0] !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL wt_hit_beat got=%h/%b/%h exp=10/1/deadbeef", log_addr[0], log_we[0], log_data[0]); end
    end
    checks++; if (hit_cnt !== 32'd2) begin errors++; $display("FAIL wt_hit_cnt got=%0d exp=2", hit_cnt); end
    clear_log();
    do_access(1'b0, 32'h10, '0, rd, lat, aw);
    checks++; if (rd !== 32'hDEAD_BEEF || lat != 2 || req_seen) begin errors++;
      $display("FAIL wt_readback got=%h lat=%0d lower=%0b exp=deadbeef lat=2 lower=0", rd, lat, req_seen); end
    clear_log();
    do_access(1'b1, 32'h20, 32'h1234_5678, rd, lat, aw);
    checks++; if (log_addr.size() != 1) begin errors++;
      $display("FAIL wt_miss_beats got=%0d exp=1", log_addr.size()); end
    else begin
      checks++; if (log_addr[0] !== 32'h20 || log_we[0] !== 1'b1 || log_data[0] !== 32'h1234_5678) begin
        errors++; $display("FAIL wt_miss_beat got=%h/%b/%h exp=20/1/12345678", log_addr[0], log_we[0], log_data[0]); end
    end
    checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL wt_miss_cnt got=%0d exp=2", miss_cnt); end
    clear_log();
    do_access(1'b0, 32'h20, '0, rd, lat, aw);
    checks++; if (log_addr.size() != 4 || rd !== 32'h1234_5678 || miss_cnt !== 32'd3) begin errors++;
      $display("FAIL wt_noalloc got beats=%0d rd=%h miss=%0d exp beats=4 rd=12345678 miss=3",
               log_addr.size(), rd, miss_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, aw;
    do_access(1'b0, 32'h24, '0, rd, lat, aw);
    checks++; if (rd !== 32'h1000_0024) begin errors++; $display("FAIL b2b_first got=%h exp=10000024", rd); end
    do_access(1'b0, 32'h28, '0, rd, lat, aw);
    checks++; if (aw != 1 || lat != 2) begin errors++;
      $display("FAIL b2b_timing got wait=%0d lat=%0d exp wait=1 lat=2", aw, lat); end
    checks++; if (rd !== 32'h1000_0028 || hit_cnt !== 32'd5) begin errors++;
      $display("FAIL b2b_second got=%h hit=%0d exp=10000028 hit=5", rd, hit_cnt); end
  endtask

  task automatic test_write_back();
    logic [31:0] rd, exp; int lat, aw;
    sel = 1'b1; init_mem(); #1; @(negedge clk);
    do_access(1'b0, 32'h10, '0, rd, lat, aw);
    checks++; if (rd !== 32'h1000_0010) begin errors++; $display("FAIL wb_fill got=%h exp=10000010", rd); end
    clear_log();
    do_access(1'b1, 32'h10, 32'hCAFE_F00D, rd, lat, aw);
    checks++; if (req_seen || lat != 2 || hit_cnt !== 32'd1) begin errors++;
      $display("FAIL wb_write_hit got lower=%0b lat=%0d hit=%0d exp lower=0 lat=2 hit=1", req_seen, lat, hit_cnt); end
    clear_log();
    do_access(1'b0, 32'h50, '0, rd, lat, aw);
    checks++; if (log_addr.size() != 8) begin errors++;
      $display("FAIL wb_evict_beats got=%0d exp=8", log_addr.size()); end
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      if (i < 4) begin
        exp = (i == 0) ? 32'hCAFE_F00D : 32'h1000_0010 + 32'(4 * i);
        checks++; if (log_addr[i] !== 32'h10 + 32'(4 * i) || log_we[i] !== 1'b1 || log_data[i] !== exp) begin
          errors++; $display("FAIL wb_evict%0d got=%h/%b/%h exp=%h/1/%h", i, log_addr[i], log_we[i],
                             log_data[i], 32'h10 + 32'(4 * i), exp); end
      end else begin
        checks++; if (log_addr[i] !== 32'h50 + 32'(4 * (i - 4)) || log_we[i] !== 1'b0) begin
          errors++; $display("FAIL wb_refill%0d got=%h/%b exp=%h/0", i, log_addr[i], log_we[i],
                             32'h50 + 32'(4 * (i - 4))); end
      end
    end
    checks++; if (rd !== 32'h1000_0050 || miss_cnt !== 32'd2) begin errors++;
      $display("FAIL wb_evict_rd got=%h miss=%0d exp=10000050 miss=2", rd, miss_cnt); end
    clear_log();
    do_access(1'b1, 32'h24, 32'h0000_0055, rd, lat, aw);
    checks++; if (log_addr.size() != 4 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h20) begin errors++;
      $display("FAIL wb_alloc got beats=%0d first=%h exp beats=4 first=20", log_addr.size(),
               log_addr.size() > 0 ? log_addr[0] : 32'hX); end
    clear_log();
    do_access(1'b0, 32'h24, '0, rd, lat, aw);
    checks++; if (rd !== 32'h0000_0055 || req_seen) begin errors++;
      $display("FAIL wb_alloc_read got=%h lower=%0b exp=55 lower=0", rd, req_seen); end
  endtask

  task automatic test_ack_delay();
    logic [31:0] rd; int lat, aw; int slow;
    ack_delay = 5; stab_viol = 0;
    do_access(1'b1, 32'h54, 32'h0BAD_F00D, rd, lat, aw);
    clear_log();
    do_access(1'b0, 32'h10, '0, rd, lat, aw);
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL delay_stable got=%0d exp=0", stab_viol); end
    slow = 0;
    foreach (log_wait[i]) if (log_wait[i] == 5) slow++;
    checks++; if (slow != 8 || log_addr.size() != 8) begin errors++;
      $display("FAIL delay_beats got=%0d/%0d exp=8/8", slow, log_addr.size()); end
    checks++; if (log_addr.size() > 1 && (log_addr[1] !== 32'h54 || log_data[1] !== 32'h0BAD_F00D)) begin
      errors++; $display("FAIL delay_evict_word got=%h/%h exp=54/0badf00d", log_addr[1], log_data[1]); end
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL delay_rdata got=%h exp=cafef00d", rd); end
    ack_delay = 0;
  endtask

  task automatic test_reset_refill();
    logic [31:0] rd; int lat, aw; int n;
    sel = 1'b0; ack_delay = 3; #1; @(negedge clk);
    clear_log();
    u_we = 1'b0; u_addr = 32'h30; u_req = 1'b1;
    @(negedge clk); u_req = 1'b0;
    n = 0;
    while (log_addr.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checks++; if (log_addr.size() < 2) begin errors++;
      $display("FAIL rr_two_beats got=%0d exp=2", log_addr.size()); end
    repeat (2) @(negedge clk);
    checks++; if (l_req !== 1'b1) begin errors++; $display("FAIL rr_inflight got=%b exp=1", l_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (l_req !== 1'b0 || u_ready !== 1'b1 || miss_cnt !== 32'd0) begin errors++;
      $display("FAIL rr_abandon got req=%b rdy=%b miss=%0d exp req=0 rdy=1 miss=0", l_req, u_ready, miss_cnt); end
    @(negedge clk); rst = 1'b0; ack_delay = 0;
    @(negedge clk);
    clear_log();
    do_access(1'b0, 32'h30, '0, rd, lat, aw);
    checks++; if (log_addr.size() != 4 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++;
      $display("FAIL rr_refetch got beats=%0d miss=%0d hit=%0d exp 4/1/0", log_addr.size(), miss_cnt, hit_cnt); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++; if (log_addr[i] !== 32'h30 + 32'(4 * i)) begin errors++;
        $display("FAIL rr_beat%0d got=%h exp=%h", i, log_addr[i], 32'h30 + 32'(4 * i)); end
    end
    checks++; if (rd !== 32'h1000_0030) begin errors++; $display("FAIL rr_rdata got=%h exp=10000030", rd); end
  endtask

  initial begin
    l_ack = 1'b0; l_rdata = '0;
    init_mem();
    test_reset();
    test_cold_read();
    test_wt_write();
    test_back_to_back();
    test_write_back();
    test_ack_delay();
    test_reset_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1);
  end

endmodule
